operand_latch_stage: RTL and testbench
======================================

// Module: operand_latch_stage
// PURPOSE
//   Decode/execute boundary register fed by the register file. Captures rs1/rs2
//   read data plus decoded control in one pipeline entry with valid/ready handshake.
//   Bypasses a same-cycle writeback, since a register file write is not visible
//   until the next edge. Keeps a held (stalled) entry coherent by snooping writebacks.
//   Counts downstream stall cycles.
// PARAMETERS
//   DATA_W      32  operand / writeback data width
//   REG_ADDR_W   5  register index width (32 architectural registers)
//   IMM_W       32  decoded immediate width
//   CTRL_W       8  opaque decoded control bundle width (ALU op, mux selects)
//   CNT_W       16  stall counter width
// PORTS
//   clock          in   1           rising-edge clock
//   reset          in   1           synchronous, active-high reset
//   in_valid       in   1           decode presents an instruction
//   in_ready       out  1           stage can accept this cycle
//   in_rs1         in   REG_ADDR_W  source register 1 index (also drives RF read_reg_num1)
//   in_rs2         in   REG_ADDR_W  source register 2 index (also drives RF read_reg_num2)
//   in_rd          in   REG_ADDR_W  destination register index
//   in_imm         in   IMM_W       decoded immediate
//   in_ctrl        in   CTRL_W      decoded control
//   rf_read_data1  in   DATA_W      RF asynchronous read of in_rs1
//   rf_read_data2  in   DATA_W      RF asynchronous read of in_rs2
//   wb_regwrite    in   1           writeback enable (same signal driving RF regwrite)
//   wb_write_reg   in   REG_ADDR_W  writeback destination index
//   wb_write_data  in   DATA_W      writeback data
//   flush          in   1           kill the held entry and any entry accepted this cycle
//   out_valid      out  1           entry valid toward execute
//   out_ready      in   1           execute consumes entry this cycle
//   out_rs1 / out_rs2  out REG_ADDR_W  held source indices (for downstream forwarding)
//   out_rs1_val / out_rs2_val  out DATA_W  held operand values
//   out_rd         out  REG_ADDR_W  held destination index
//   out_imm        out  IMM_W       held immediate
//   out_ctrl       out  CTRL_W      held control
//   stall_count    out  CNT_W       cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//   - Reset (sync): out_valid=0, every out_* field=0, stall_count=0. in_ready reads 1 after reset.
//   - in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready & ~flush.
//   - Latency: 1 cycle. Entry accepted at edge N is presented from edge N with out_valid=1.
//   - Operand capture on accept, per source s (rs1/rs2), priority order:
//       in_rs == 0                                    -> 0  (x0 is always zero, regardless of RF content)
//       wb_regwrite & wb_write_reg == in_rs           -> wb_write_data (bypass)
//       otherwise                                     -> rf_read_data
//   - Held-entry snoop: out_valid=1, no accept, wb_regwrite=1, wb_write_reg==out_rsX,
//     out_rsX!=0 -> out_rsX_val <= wb_write_data at the edge. A rs1==rs2 match updates both.
//   - Transitions at each edge: flush -> out_valid<=0 (highest priority; data fields may hold).
//     Else accept -> load the new entry, out_valid<=1. Else out_ready -> out_valid<=0.
//     Else hold, with snoop applied.
//   - Simultaneous consume+accept: the departing entry leaves unmodified. The new entry takes
//     its bypass values. Back-to-back throughput is 1 entry/cycle.
//   - Writeback to x0: never bypassed and never snooped.
//   - stall_count increments when out_valid & ~out_ready & ~flush. Saturates at 2^CNT_W-1.
//     Only reset clears it.
//   - Reset asserted mid-stall: entry dropped, the counter is cleared, and snooping has no effect that cycle.
// TESTING
//   - Reset 2 cycles -> out_valid=0, stall_count=0, in_ready=1. Accept rs1=3, rs2=4 with RF data 3/4,
//     out_ready=1 -> next cycle out_rs1_val=3, out_rs2_val=4, out_valid=1 for 1 cycle.
//   - Accept rs1=5 while wb_regwrite=1, wb_write_reg=5, wb_write_data=0xDEAD, RF data=5
//     -> out_rs1_val=0xDEAD.
//   - rs1=0, rs2=0, wb_write_reg=0, wb_write_data=0xFFFF, RF data 0x1234 -> both operands 0.
//   - Hold entry (rs2=7) with out_ready=0 for 4 cycles. In cycle 2, write x7=0xBEEF
//     -> out_rs2_val=0xBEEF, entry unchanged otherwise, stall_count=4, in_ready=0 throughout.
//   - Stalled entry plus in_valid=1 and flush=1 -> out_valid=0 next cycle, nothing accepted,
//     and stall_count does not increment in the flush cycle.
//   - Stream 10 instructions with out_ready=1 -> 10 outputs on consecutive cycles in order.
//     Then force stall_count to near-max (CNT_W=4) -> the count holds at 15.

Source files
------------

// File: rtl/operand_latch_stage.sv
// Decode/execute boundary register: captures register-file operands plus decoded
// control, bypasses same-cycle writebacks and snoops writebacks into a stalled entry.
module operand_latch_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMM_W      = 32,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     rf_read_data1,
  input  logic [DATA_W-1:0]     rf_read_data2,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [DATA_W-1:0]     out_rs1_val,
  output logic [DATA_W-1:0]     out_rs2_val,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [IMM_W-1:0]      out_imm,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [CNT_W-1:0]      stall_count
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [DATA_W-1:0]     r_rs1_val;
  logic [DATA_W-1:0]     r_rs2_val;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [IMM_W-1:0]      r_imm;
  logic [CTRL_W-1:0]     r_ctrl;
  logic [CNT_W-1:0]      r_stall;

  logic              w_ready;
  logic              w_accept;
  logic              w_stall_inc;
  logic              w_snoop1;
  logic              w_snoop2;
  logic [DATA_W-1:0] w_rs1_cap;
  logic [DATA_W-1:0] w_rs2_cap;

  assign w_ready     = ~r_valid | out_ready;
  assign w_accept    = in_valid & w_ready & ~flush;
  assign w_stall_inc = r_valid & ~out_ready & ~flush;

  // The RF write lands at the same edge as capture, so a matching writeback
  // must be taken directly; x0 stays zero whatever the RF or writeback says.
  always_comb begin
    w_rs1_cap = '0;
    w_rs2_cap = '0;
    if (in_rs1 != '0) begin
      if (wb_regwrite && (wb_write_reg == in_rs1)) w_rs1_cap = wb_write_data;
      else                                         w_rs1_cap = rf_read_data1;
    end
    if (in_rs2 != '0) begin
      if (wb_regwrite && (wb_write_reg == in_rs2)) w_rs2_cap = wb_write_data;
      else                                         w_rs2_cap = rf_read_data2;
    end
  end

  assign w_snoop1 = wb_regwrite && (wb_write_reg == r_rs1) && (r_rs1 != '0);
  assign w_snoop2 = wb_regwrite && (wb_write_reg == r_rs2) && (r_rs2 != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_ctrl    <= '0;
      r_stall   <= '0;
    end else begin
      if (w_stall_inc && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);

      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_rs1     <= in_rs1;
        r_rs2     <= in_rs2;
        r_rs1_val <= w_rs1_cap;
        r_rs2_val <= w_rs2_cap;
        r_rd      <= in_rd;
        r_imm     <= in_imm;
        r_ctrl    <= in_ctrl;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end else if (r_valid) begin
        // Held entry tracks the register file so it is never stale on release.
        if (w_snoop1) r_rs1_val <= wb_write_data;
        if (w_snoop2) r_rs2_val <= wb_write_data;
      end
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = r_valid;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_rs1_val = r_rs1_val;
  assign out_rs2_val = r_rs2_val;
  assign out_rd      = r_rd;
  assign out_imm     = r_imm;
  assign out_ctrl    = r_ctrl;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_operand_latch_stage.sv
// Bench for operand_latch_stage: directed vector table, hand-written stall/flush/reset
// sequences and a randomized run against an architectural register-file model.
module tb_operand_latch_stage;

  localparam int unsigned CNT_MAX = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic [7:0]  in_ctrl;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_regwrite;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm;
  logic [7:0]  out_ctrl;
  logic [3:0]  stall_count;

  operand_latch_stage #(
    .DATA_W(32), .REG_ADDR_W(5), .IMM_W(32), .CTRL_W(8), .CNT_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_imm(out_imm), .out_ctrl(out_ctrl), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Architectural state: register file contents and the entry expected at execute.
  logic [31:0] regs [32];
  bit          m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_imm;
  logic [7:0]  m_ctrl;
  int          m_cnt;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd, exp1, exp2;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] arch_val(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : regs[r];
  endfunction

  task automatic drive(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [7:0] ctrl,
                       input bit wbe, input logic [4:0] wbr, input logic [31:0] wbd,
                       input bit fl, input bit ordy);
    in_valid = iv; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_ctrl = ctrl;
    rf_read_data1 = regs[rs1];
    rf_read_data2 = regs[rs2];
    wb_regwrite = wbe; wb_write_reg = wbr; wb_write_data = wbd;
    flush = fl; out_ready = ordy;
  endtask

  task automatic idle(input bit ordy);
    drive(0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 0, 5'd0, 32'd0, 0, ordy);
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic cycle();
    bit rdy, acc;
    #1;
    rdy = !m_valid || out_ready;
    check("in_ready", in_ready, rdy);
    acc = in_valid && rdy && !flush;
    if (reset) begin
      m_valid = 0; m_cnt = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_ctrl = 0;
    end else begin
      if (m_valid && !out_ready && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; m_imm = in_imm; m_ctrl = in_ctrl;
      end else if (out_ready) m_valid = 0;
    end
    if (wb_regwrite) regs[wb_write_reg] = wb_write_data;
    @(posedge clock);
    #1;
    check("out_valid", out_valid, m_valid);
    check("stall_count", stall_count, m_cnt[3:0]);
    if (m_valid) begin
      check("out_rs1", out_rs1, m_rs1);
      check("out_rs2", out_rs2, m_rs2);
      check("out_rd", out_rd, m_rd);
      check("out_imm", out_imm, m_imm);
      check("out_ctrl", out_ctrl, m_ctrl);
      check("out_rs1_val", out_rs1_val, arch_val(m_rs1));
      check("out_rs2_val", out_rs2_val, arch_val(m_rs2));
    end
  endtask

  task automatic sync_reset();
    idle(0);
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    m_valid = 0; m_cnt = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_ctrl = 0;

    vecs[0] = '{5'd3,  5'd4,  32'd3,      32'd4,      1'b0, 5'd0,  32'd0,      32'd3,      32'd4};
    vecs[1] = '{5'd5,  5'd6,  32'd5,      32'h66,     1'b1, 5'd5,  32'hDEAD,   32'hDEAD,   32'h66};
    vecs[2] = '{5'd0,  5'd0,  32'h1234,   32'h1234,   1'b1, 5'd0,  32'hFFFF,   32'd0,      32'd0};
    vecs[3] = '{5'd9,  5'd9,  32'h11,     32'h11,     1'b1, 5'd9,  32'hCAFE,   32'hCAFE,   32'hCAFE};
    vecs[4] = '{5'd10, 5'd11, 32'hA,      32'hB,      1'b1, 5'd12, 32'h77,     32'hA,      32'hB};
    vecs[5] = '{5'd0,  5'd13, 32'h5555,   32'hD,      1'b1, 5'd13, 32'h1,      32'd0,      32'h1};

    // Initial reset: DUT state is unknown until the first edge, so check only afterwards.
    idle(0);
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_count", stall_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rs1_val", out_rs1_val, 0);
    check("rst_imm", out_imm, 0);

    // Directed capture table: accept with consumer ready, present for exactly one cycle.
    for (int i = 0; i < 6; i++) begin
      regs[vecs[i].rs1] = vecs[i].rf1;
      regs[vecs[i].rs2] = vecs[i].rf2;
      drive(1, vecs[i].rs1, vecs[i].rs2, 5'd1, 32'h40 + i, 8'(i), vecs[i].wbe, vecs[i].wbr,
            vecs[i].wbd, 0, 1);
      cycle();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_rs1_val", i), out_rs1_val, vecs[i].exp1);
      check($sformatf("vec%0d_rs2_val", i), out_rs2_val, vecs[i].exp2);
      idle(1);
      cycle();
      check($sformatf("vec%0d_gone", i), out_valid, 0);
    end

    // Stall with a writeback to the held rs2 in the second stalled cycle.
    sync_reset();
    regs[7] = 32'h7777;
    drive(1, 5'd1, 5'd7, 5'd2, 32'h100, 8'h5A, 0, 5'd0, 32'd0, 0, 0);
    cycle();
    check("hold_start_cnt", stall_count, 0);
    check("hold_start_rs2", out_rs2_val, 32'h7777);
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd3, 5'd4, 5'd5, 32'h200, 8'h00, (i == 1), 5'd7, 32'hBEEF, 0, 0);
      cycle();
      check("hold_in_ready", in_ready, 0);
    end
    check("hold_rs2_val", out_rs2_val, 32'hBEEF);
    check("hold_rs1_val", out_rs1_val, 32'h1001);
    check("hold_imm", out_imm, 32'h100);
    check("hold_rd", out_rd, 2);
    check("hold_ctrl", out_ctrl, 8'h5A);
    check("hold_cnt", stall_count, 4);

    // Flush while stalled with a competing request.
    drive(1, 5'd3, 5'd4, 5'd5, 32'h300, 8'h00, 0, 5'd0, 32'd0, 1, 0);
    cycle();
    check("flush_valid", out_valid, 0);
    check("flush_cnt", stall_count, 4);

    // Reset in the middle of a stall while a writeback targets the held rs1.
    drive(1, 5'd6, 5'd7, 5'd8, 32'h400, 8'h01, 0, 5'd0, 32'd0, 0, 0);
    cycle();
    idle(0);
    cycle();
    cycle();
    check("pre_rst_cnt", stall_count, 6);
    drive(0, 5'd0, 5'd0, 5'd0, 32'd0, 8'd0, 1, 5'd6, 32'h1111, 0, 0);
    reset = 1;
    cycle();
    reset = 0;
    check("midrst_valid", out_valid, 0);
    check("midrst_cnt", stall_count, 0);
    check("midrst_rs1_val", out_rs1_val, 0);

    // Back-to-back stream of 10 entries.
    for (int i = 0; i < 10; i++) begin
      drive(1, 5'(i + 1), 5'(i + 2), 5'(i), 32'hA00 + i, 8'(i), 0, 5'd0, 32'd0, 0, 1);
      cycle();
      check("stream_valid", out_valid, 1);
      check("stream_order", out_imm, 32'hA00 + i);
    end
    idle(1);
    cycle();
    check("stream_end", out_valid, 0);

    // Long stall to saturate the 4-bit counter.
    drive(1, 5'd2, 5'd3, 5'd4, 32'h500, 8'h02, 0, 5'd0, 32'd0, 0, 0);
    cycle();
    idle(0);
    for (int i = 0; i < 20; i++) cycle();
    check("sat_cnt", stall_count, 15);
    check("sat_valid", out_valid, 1);

    // Randomized traffic on a narrow register range to force hazards.
    sync_reset();
    for (int i = 0; i < 400; i++) begin
      regs[0] = $urandom;
      drive($urandom_range(3, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
            5'($urandom_range(31, 0)), $urandom, 8'($urandom),
            $urandom_range(1, 0) == 1, 5'($urandom_range(7, 0)), $urandom,
            $urandom_range(15, 0) == 0, $urandom_range(1, 0) == 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
